adc_dual_slope_ctrl: RTL and testbench

// Control and readout for a dual-slope integrating ADC. A Moore FSM drives the analog switches
// (zero, measured input, reference) and sequences a 3-digit BCD counter. The integrate phase

---
 rtl/adc_dual_slope_ctrl_pkg.sv | 56 +++++
 rtl/adc_dual_slope_ctrl_if.sv | 34 +++
 rtl/adc_dual_slope_ctrl_bcd_seg7_decoder.sv | 20 ++
 rtl/adc_dual_slope_ctrl.sv | 155 +++++++++++++++
 tb/tb_adc_dual_slope_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/adc_dual_slope_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_pkg
//  Brief    : Shared types and segment constants for the dual-slope ADC
//             controller.
//  Revision : 1.0  initial release
// ============================================================================
package adc_pkg;

    // Controller phases. The width is fixed so the encoding never changes.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        INTEG = 3'd2,
        DEINT = 3'd3,
        LOAD  = 3'd4
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'h3F;
    localparam logic [6:0] c_SEG_1     = 7'h06;
    localparam logic [6:0] c_SEG_2     = 7'h5B;
    localparam logic [6:0] c_SEG_3     = 7'h4F;
    localparam logic [6:0] c_SEG_4     = 7'h66;
    localparam logic [6:0] c_SEG_5     = 7'h6D;
    localparam logic [6:0] c_SEG_6     = 7'h7D;
    localparam logic [6:0] c_SEG_7     = 7'h07;
    localparam logic [6:0] c_SEG_8     = 7'h7F;
    localparam logic [6:0] c_SEG_9     = 7'h6F;
    localparam logic [6:0] c_SEG_DASH  = 7'h40;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

    // Counter value that produces the carry out of the hundreds digit
    localparam logic [11:0] c_CNT_MAX  = 12'h999;

    // BCD digit to active-high segments; non-decimal codes are blanked
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = c_SEG_0;
            4'd1:    seg = c_SEG_1;
            4'd2:    seg = c_SEG_2;
            4'd3:    seg = c_SEG_3;
            4'd4:    seg = c_SEG_4;
            4'd5:    seg = c_SEG_5;
            4'd6:    seg = c_SEG_6;
            4'd7:    seg = c_SEG_7;
            4'd8:    seg = c_SEG_8;
            4'd9:    seg = c_SEG_9;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_dual_slope_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : adc_dual_slope_ctrl_if
//  Brief    : Analog-switch / comparator / display signal bundle of the
//             dual-slope ADC controller.
//  Revision : 1.0  initial release
// ============================================================================
interface adc_dual_slope_ctrl_if;
    logic       inicio;
    logic       Vint_z;
    logic       ch_zr;
    logic       ch_vm;
    logic       ch_ref;
    logic       enb_0;
    logic       rst_s;
    logic       ld;
    logic       enb_3;
    logic [6:0] sgm0;
    logic [6:0] sgm1;
    logic [6:0] sgm2;

    // Controller side
    modport master (
        input  inicio, Vint_z,
        output ch_zr, ch_vm, ch_ref, enb_0, rst_s, ld, enb_3, sgm0, sgm1, sgm2
    );

    // Front-end / board side
    modport slave (
        output inicio, Vint_z,
        input  ch_zr, ch_vm, ch_ref, enb_0, rst_s, ld, enb_3, sgm0, sgm1, sgm2
    );
endinterface
`default_nettype wire

// File: rtl/adc_dual_slope_ctrl_bcd_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seg7_decoder
//  Brief    : One BCD digit to active-high 7-segment pattern {g,f,e,d,c,b,a}.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_seg7_decoder
    import adc_pkg::*;
(
    input  wire logic [3:0] i_bcd,
    output logic      [6:0] o_seg
);

    // Pure table lookup; invalid codes blank the digit
    always_comb begin
        o_seg = bcd_to_seg(i_bcd);
    end

endmodule
`default_nettype wire

// File: rtl/adc_dual_slope_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adc_dual_slope_ctrl
//  Brief    : Dual-slope integrating ADC sequencer: switch control FSM,
//             3-digit BCD counter, display latch and 7-segment readout.
//  Revision : 1.0  initial release
// ============================================================================
module adc_dual_slope_ctrl
    import adc_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
)(
    input  wire logic              ck,
    input  wire logic              rst_n,
    adc_dual_slope_ctrl_if.master  bus
);

    state_t      r_state_q, w_state_d;
    logic [11:0] r_cnt_q,   w_cnt_d;
    logic [11:0] r_disp_q,  w_disp_d;
    logic        r_ovf_q,   w_ovf_d;
    logic        r_ovfd_q,  w_ovfd_d;

    logic        w_ch_zr, w_ch_vm, w_ch_ref;
    logic        w_enb_0, w_rst_s, w_ld, w_enb_3;
    logic [6:0]  w_seg_raw [3];
    logic [6:0]  w_seg     [3];

    // Carry out of the hundreds digit: last count of a 1000-count window
    assign w_enb_3 = w_enb_0 && (r_cnt_q == c_CNT_MAX);

    // State register; reset aborts any conversion
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next state and Moore outputs; exactly one analog switch closed per state
    always_comb begin
        w_state_d = r_state_q;
        w_ch_zr   = 1'b0;
        w_ch_vm   = 1'b0;
        w_ch_ref  = 1'b0;
        w_enb_0   = 1'b0;
        w_rst_s   = 1'b0;
        w_ld      = 1'b0;
        case (r_state_q)
            IDLE: begin
                w_ch_zr = 1'b1;
                if (bus.inicio) w_state_d = CLR;
            end
            CLR: begin
                w_ch_zr   = 1'b1;
                w_rst_s   = 1'b1;
                w_state_d = INTEG;
            end
            INTEG: begin
                w_ch_vm = 1'b1;
                w_enb_0 = 1'b1;
                if (r_cnt_q == c_CNT_MAX) w_state_d = DEINT;
            end
            DEINT: begin
                w_ch_ref = 1'b1;
                w_enb_0  = 1'b1;
                if (bus.Vint_z || (r_cnt_q == c_CNT_MAX)) w_state_d = LOAD;
            end
            LOAD: begin
                w_ch_zr   = 1'b1;
                w_ld      = 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_ch_zr   = 1'b1;
                w_state_d = IDLE;
            end
        endcase
    end

    // Decimal counter, overflow flag and display latch next values
    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_ovf_d  = r_ovf_q;
        w_disp_d = r_disp_q;
        w_ovfd_d = r_ovfd_q;
        if (w_rst_s) begin
            w_cnt_d = 12'h000;
            w_ovf_d = 1'b0;
        end else if (w_enb_0) begin
            if (r_cnt_q[3:0] != 4'd9) begin
                w_cnt_d[3:0] = r_cnt_q[3:0] + 4'd1;
            end else begin
                w_cnt_d[3:0] = 4'd0;
                if (r_cnt_q[7:4] != 4'd9) begin
                    w_cnt_d[7:4] = r_cnt_q[7:4] + 4'd1;
                end else begin
                    w_cnt_d[7:4] = 4'd0;
                    if (r_cnt_q[11:8] != 4'd9) begin
                        w_cnt_d[11:8] = r_cnt_q[11:8] + 4'd1;
                    end else begin
                        w_cnt_d[11:8] = 4'd0;
                    end
                end
            end
            // Reference phase ran a full window without a zero crossing
            if ((r_state_q == DEINT) && w_enb_3) w_ovf_d = 1'b1;
        end
        if (w_ld) begin
            w_disp_d = r_cnt_q;
            w_ovfd_d = r_ovf_q;
        end
    end

    // Counter, overflow and display registers
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q  <= 12'h000;
            r_ovf_q  <= 1'b0;
            r_disp_q <= 12'h000;
            r_ovfd_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_ovf_q  <= w_ovf_d;
            r_disp_q <= w_disp_d;
            r_ovfd_q <= w_ovfd_d;
        end
    end

    // One decoder per displayed digit; overflow replaces digits with dashes
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            bcd_seg7_decoder u_dec (
                .i_bcd (r_disp_q[4*gi +: 4]),
                .o_seg (w_seg_raw[gi])
            );
            assign w_seg[gi] = (r_ovfd_q ? c_SEG_DASH : w_seg_raw[gi])
                               ^ {7{SEG_ACTIVE_LOW}};
        end
    endgenerate

    assign bus.ch_zr  = w_ch_zr;
    assign bus.ch_vm  = w_ch_vm;
    assign bus.ch_ref = w_ch_ref;
    assign bus.enb_0  = w_enb_0;
    assign bus.rst_s  = w_rst_s;
    assign bus.ld     = w_ld;
    assign bus.enb_3  = w_enb_3;
    assign bus.sgm0   = w_seg[0];
    assign bus.sgm1   = w_seg[1];
    assign bus.sgm2   = w_seg[2];

endmodule
`default_nettype wire

// File: tb/tb_adc_dual_slope_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_dual_slope_ctrl
//  Brief    : Self-checking bench for the dual-slope ADC controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_dual_slope_ctrl;

    localparam bit c_ACT_LOW = 1'b0;
    localparam int c_P_IDLE = 0, c_P_CLR = 1, c_P_INT = 2, c_P_DEI = 3, c_P_LD = 4;

    logic ck    = 1'b0;
    logic rst_n = 1'b0;

    adc_dual_slope_ctrl_if bus ();

    adc_dual_slope_ctrl #(.SEG_ACTIVE_LOW(c_ACT_LOW)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus an integer cycle count within the phase window
    int m_phase = c_P_IDLE;
    int m_cnt   = 0;
    int m_disp  = 0;
    bit m_ovf   = 1'b0;
    bit m_ovfd  = 1'b0;

    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = c_P_IDLE; m_cnt = 0; m_disp = 0; m_ovf = 1'b0; m_ovfd = 1'b0;
        end else begin
            bit last;
            last = (m_cnt == 999);
            case (m_phase)
                c_P_IDLE: if (bus.inicio === 1'b1) m_phase = c_P_CLR;
                c_P_CLR:  begin m_cnt = 0; m_ovf = 1'b0; m_phase = c_P_INT; end
                c_P_INT:  begin m_cnt = (m_cnt + 1) % 1000; if (last) m_phase = c_P_DEI; end
                c_P_DEI:  begin
                    m_cnt = (m_cnt + 1) % 1000;
                    if (last) m_ovf = 1'b1;
                    if (last || bus.Vint_z === 1'b1) m_phase = c_P_LD;
                end
                default:  begin m_disp = m_cnt; m_ovfd = m_ovf; m_phase = c_P_IDLE; end
            endcase
        end
    end

    function automatic logic [6:0] exp_seg(input int digit);
        logic [6:0] s;
        s = m_ovfd ? 7'h40 : seg_tab[digit];
        return s ^ {7{c_ACT_LOW}};
    endfunction

    // Compare every output against the model one time unit after each edge
    always @(posedge ck) begin
        #1;
        if (rst_n) begin
            bit counting;
            counting = (m_phase == c_P_INT) || (m_phase == c_P_DEI);
            chk("ch_zr",  bus.ch_zr,  (m_phase == c_P_IDLE || m_phase == c_P_CLR || m_phase == c_P_LD));
            chk("ch_vm",  bus.ch_vm,  (m_phase == c_P_INT));
            chk("ch_ref", bus.ch_ref, (m_phase == c_P_DEI));
            chk("enb_0",  bus.enb_0,  counting);
            chk("rst_s",  bus.rst_s,  (m_phase == c_P_CLR));
            chk("ld",     bus.ld,     (m_phase == c_P_LD));
            chk("enb_3",  bus.enb_3,  (counting && m_cnt == 999));
            chk("sgm0",   bus.sgm0,   exp_seg(m_disp % 10));
            chk("sgm1",   bus.sgm1,   exp_seg((m_disp / 10) % 10));
            chk("sgm2",   bus.sgm2,   exp_seg(m_disp / 100));
        end
    end

    // One conversion: Vint_z on DEINT edge n (0 = never); ign adds ignored pulses
    task automatic convert(input int n, input bit ign,
                           input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0,
                           input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        int vm_cyc, ref_cyc, guard, e3_cnt;
        vm_cyc = 0; ref_cyc = 0; guard = 0; e3_cnt = 0;
        @(negedge ck) bus.inicio = 1'b1;
        @(negedge ck) bus.inicio = 1'b0;
        while (bus.ch_ref !== 1'b1 && guard < 1200) begin
            if (bus.ch_vm === 1'b1) vm_cyc++;
            if (bus.enb_3 === 1'b1) e3_cnt++;
            bus.inicio = ign && (vm_cyc == 500);
            bus.Vint_z = ign && (vm_cyc == 600);
            @(negedge ck);
            guard++;
        end
        bus.inicio = 1'b0; bus.Vint_z = 1'b0;
        chk("integ_len", vm_cyc, 1000);
        chk("integ_enb3_pulses", e3_cnt, 1);
        chk("hold_sgm2", bus.sgm2, p2);
        chk("hold_sgm1", bus.sgm1, p1);
        chk("hold_sgm0", bus.sgm0, p0);
        guard = 0;
        while (bus.ch_ref === 1'b1 && guard < 1100) begin
            ref_cyc++;
            bus.Vint_z = (n > 0) && (ref_cyc == n);
            bus.inicio = ign && (ref_cyc == 3);
            @(negedge ck);
            guard++;
        end
        bus.Vint_z = 1'b0; bus.inicio = 1'b0;
        chk("deint_len", ref_cyc, (n > 0) ? n : 1000);
        chk("ld_pulse", bus.ld, 1'b1);
        @(negedge ck);
        chk("ld_done", bus.ld, 1'b0);
        chk("back_idle_zr", bus.ch_zr, 1'b1);
        chk("disp_sgm2", bus.sgm2, e2);
        chk("disp_sgm1", bus.sgm1, e1);
        chk("disp_sgm0", bus.sgm0, e0);
    endtask

    initial begin
        bus.inicio = 1'b0;
        bus.Vint_z = 1'b0;
        #1;
        chk("rst_ch_zr",  bus.ch_zr,  1'b1);
        chk("rst_ch_vm",  bus.ch_vm,  1'b0);
        chk("rst_ch_ref", bus.ch_ref, 1'b0);
        chk("rst_ld",     bus.ld,     1'b0);
        chk("rst_sgm",    {bus.sgm2, bus.sgm1, bus.sgm0}, {7'h3F, 7'h3F, 7'h3F});
        repeat (3) @(negedge ck);
        rst_n = 1'b1;
        repeat (5) @(negedge ck);
        chk("idle_stays", bus.ch_zr, 1'b1);

        // Nominal "150" with ignored stimulus sprinkled in
        convert(150, 1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h6D, 7'h3F);
        // Back-to-back "007"; display must still read "150" during conversion
        convert(7, 1'b0, 7'h06, 7'h6D, 7'h3F, 7'h3F, 7'h3F, 7'h07);
        // Overflow: no zero crossing
        convert(0, 1'b0, 7'h3F, 7'h3F, 7'h07, 7'h40, 7'h40, 7'h40);
        // Next good conversion clears the overflow
        convert(42, 1'b0, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h66, 7'h5B);

        // Asynchronous reset in the middle of DEINT
        begin
            int guard;
            guard = 0;
            @(negedge ck) bus.inicio = 1'b1;
            @(negedge ck) bus.inicio = 1'b0;
            while (bus.ch_ref !== 1'b1 && guard < 1200) begin
                @(negedge ck);
                guard++;
            end
            chk("reach_deint", bus.ch_ref, 1'b1);
            repeat (50) @(negedge ck);
            #2 rst_n = 1'b0;
            #1;
            chk("arst_ch_zr",  bus.ch_zr,  1'b1);
            chk("arst_ch_ref", bus.ch_ref, 1'b0);
            chk("arst_enb_0",  bus.enb_0,  1'b0);
            chk("arst_sgm",    {bus.sgm2, bus.sgm1, bus.sgm0}, {7'h3F, 7'h3F, 7'h3F});
            @(negedge ck) rst_n = 1'b1;
            repeat (4) @(negedge ck);
            chk("post_arst_idle", bus.ch_zr, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
